// File: rtl/prbs_pkg.sv
// Shared constants and helpers for the PRBS30 checker.
// The polynomial is x^30 + x^29 + x^26 + x^24 + 1.
package prbs_pkg;

  localparam int LFSR_W = 30;

  // Feedback taps are zero-based bit positions of the shift register.
  localparam int TAP_A = 29;
  localparam int TAP_B = 28;
  localparam int TAP_C = 25;
  localparam int TAP_D = 24;

  localparam logic [LFSR_W-1:0] SEED_VAL = 30'h200;

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
  endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational count of the set bits in a 30-bit word.
// The result range is 0..30, so 5 output bits are enough.
module prbs_popcount
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] din_i,
  output logic [4:0]        cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < LFSR_W; i++) cnt_o = cnt_o + 5'(din_i[i]);
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS30 stream checker: seeds from received data, locks after a run of
// matches, then flywheels the local LFSR and counts word and bit errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 3,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  bit_err_count,
  output logic [CNT_W-1:0]  word_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(UNLOCK_ERRORS + 1);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [MW-1:0]     mcnt_q, mcnt_d;
  logic [XW-1:0]     miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;

  logic              mismatch;
  logic              cnt_word, cnt_err;
  logic [4:0]        nbits;
  logic [CNT_W:0]    bsum;

  assign mismatch = (data_in != exp_q);

  prbs_popcount u_pop (
    .din_i (data_in ^ exp_q),
    .cnt_o (nbits)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    mcnt_d   = mcnt_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    cnt_word = 1'b0;
    cnt_err  = 1'b0;
    if (ena) begin
      unique case (state_q)
        ST_SEED: begin
          // An all-zero word is the LFSR lockup state and cannot seed.
          if (data_in != '0) begin
            exp_d   = step(data_in);
            mcnt_d  = '0;
            state_d = ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (!mismatch) begin
            exp_d  = step(data_in);
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q + 1'b1 == MW'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (data_in == '0) begin
            state_d = ST_SEED;
          end else begin
            exp_d  = step(data_in);
            mcnt_d = '0;
          end
        end
        ST_LOCKED: begin
          exp_d    = step(exp_q);
          cnt_word = 1'b1;
          if (mismatch) begin
            err_d   = 1'b1;
            cnt_err = 1'b1;
            miss_d  = miss_q + 1'b1;
            if (miss_q + 1'b1 == XW'(UNLOCK_ERRORS)) begin
              state_d = ST_SEED;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = ST_SEED;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Saturating statistics; a clear wins over the word seen in the same cycle.
  assign bsum = {1'b0, bcnt_q} + (CNT_W+1)'(nbits);

  always_comb begin
    ecnt_d = ecnt_q;
    bcnt_d = bcnt_q;
    wcnt_d = wcnt_q;
    if (clr) begin
      ecnt_d = '0;
      bcnt_d = '0;
      wcnt_d = '0;
    end else begin
      if (cnt_word && wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
      if (cnt_err) begin
        if (ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
        bcnt_d = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEED;
      exp_q    <= '0;
      mcnt_q   <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      mcnt_q   <= mcnt_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
      bcnt_q   <= bcnt_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign locked        = locked_q;
  assign err           = err_q;
  assign err_count     = ecnt_q;
  assign bit_err_count = bcnt_q;
  assign word_count    = wcnt_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words required after seeding before lock is declared.
REQ-002 SHALL have parameter UNLOCK_ERRORS, default 3: consecutive mismatching words while locked that drop lock.
REQ-003 SHALL have parameter CNT_W, default 32: width of all statistics counters.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  data_in valid this cycle.
- data_in  in  30  received LFSR word.
- clr  in  1  synchronous counter clear.
- locked  out  1  checker is locked to the stream.
- err  out  1  one-cycle pulse for a mismatching word while locked.
- err_count  out  CNT_W  count of mismatching words.
- bit_err_count  out  CNT_W  count of mismatching bits.
- word_count  out  CNT_W  count of words checked while locked.

Function
REQ-005 SHALL use step(x) = {x[28:0], x[29]^x[28]^x[25]^x[24]}, the polynomial x30+x29+x26+x24+1, for every prediction.
REQ-006 SHALL implement states SEED, LOCKING and LOCKED, hold a 30-bit expected register, and do nothing in any state on a cycle with ena=0.
REQ-007 In SEED, on ena with data_in non-zero, SHALL load expected=step(data_in), clear the match counter and go to LOCKING.
REQ-008 In SEED, SHALL ignore data_in=0, the LFSR lockup word.
REQ-009 In LOCKING, on ena with data_in==expected, SHALL increment the match counter, load expected=step(data_in), and go to LOCKED when the match count reaches LOCK_COUNT.
REQ-010 In LOCKING, on ena with a mismatch, SHALL reseed (expected=step(data_in), match counter=0), or go to SEED if data_in=0.
REQ-011 In LOCKED, SHALL flywheel on every ena: expected=step(expected), never reloaded from data_in.
REQ-012 In LOCKED, on a mismatching word, SHALL pulse err for one cycle, increment err_count and the miss counter, and add popcount(data_in^expected) (0..30) to bit_err_count.
REQ-013 In LOCKED, on a matching word, SHALL clear the miss counter.
REQ-014 In LOCKED, SHALL go to SEED when the miss counter reaches UNLOCK_ERRORS; the word that trips it is still counted.
REQ-015 SHALL increment word_count on every ena while in LOCKED, whether the word matches or not.
REQ-016 SHALL drive all outputs from registers: err and counter updates visible the cycle after the ena sample, and locked=1 exactly while in LOCKED.
REQ-017 SHALL saturate all counters at all-ones with no wrap.
REQ-018 SHALL give clr priority over a simultaneous count event: counters read 0 next cycle, the concurrent word is not counted, and FSM/err behaviour is unaffected.
REQ-019 SHALL neither update counters nor pulse err in SEED or LOCKING.

Reset
REQ-020 On rst_n=0 SHALL immediately, without waiting for clk, set state to SEED, expected to 0, match and miss counters to 0, and locked, err and all counters to 0.
REQ-021 Reset asserted mid-lock SHALL require a full reseed on release, with no retained state.

Structure
REQ-022 A shared package prbs_pkg SHALL hold LFSR_W=30, the tap positions, SEED_VAL=30'h200, the step function and the state enum.
REQ-023 Bit-error counting SHALL live in one sub-module, prbs_popcount: 30-bit in, 5-bit count out, combinational.

Verification
REQ-024 Reset, then generator words from seed 30'h200 with ena every cycle: locked rises after the 5th word; after 100 words err_count=0 and word_count=95.
REQ-025 Locked, bit 0 of one word flipped: err high exactly one cycle, err_count=1, bit_err_count=1, locked stays 1, the next correct word gives no err.
REQ-026 Locked, 3 consecutive words bit-inverted: err_count=3, bit_err_count=90, locked falls after the 3rd; 5 further good words relock.
REQ-027 ena=1, data_in=0 for 10 cycles after reset: state stays SEED, locked=0, all counters 0.
REQ-028 clr asserted in the same cycle as a mismatching locked word: all counters 0 next cycle, err pulses, locked stays 1.
REQ-029 rst_n pulsed low mid-lock, between clock edges: locked and counters 0 before the next edge; relock needs 5 words.
